regfile_sb: RTL and testbench

//  Parametrised multi-read-port register file with a per-register busy scoreboard and write-to-read bypass.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 28 ++
 rtl/regfile_sb.sv | 71 +++++++
 tb/tb_regfile_sb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the scoreboarded register file
package regfile_pkg;
    localparam int XZR_IDX = 31;
    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 32;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef logic [$clog2(DEF_DEPTH)-1:0] rf_addr_t;
    typedef logic [DEF_WIDTH-1:0] rf_data_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read mux with write bypass and busy masking
module regfile_read_port import regfile_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ZERO_REG = XZR_IDX,
    parameter int BYPASS = 1,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic                         reset,
    input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
    input  logic [DEPTH-1:0]             busy,
    input  logic [AW-1:0]                addr,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             data,
    output logic                         pending
);
    logic zero, hit;

    // the in-flight write both forwards its data and retires the pending flag
    always_comb begin
        zero = reset || addr == AW'(ZERO_REG);
        hit = wr_en && wr_addr == addr;
        data = zero ? '0 : (BYPASS != 0 && hit) ? wr_data : regs[addr];
        pending = !zero && busy[addr] && !hit;
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with hardwired zero register,
// write-to-read bypass and a per-register pending-write scoreboard
module regfile_sb import regfile_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int ZERO_REG = XZR_IDX,
    parameter int BYPASS = 1,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     busy_set_en,
    input  logic [AW-1:0]            busy_set_addr,
    input  logic                     flush
);
    logic [WIDTH-1:0] mem [DEPTH-1];
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0] busy, wr_sel, set_sel, zmask;

    always_comb begin
        zmask = ~(DEPTH'(1) << ZERO_REG);
        wr_sel = wr_en ? (DEPTH'(1) << wr_addr) & zmask : '0;
        set_sel = busy_set_en ? (DEPTH'(1) << busy_set_addr) & zmask : '0;
    end

    // the zero register has no storage slot, so indices above it shift down by one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (i != ZERO_REG && wr_sel[i]) mem[i < ZERO_REG ? i : i - 1] <= wr_data;
        end
    end

    always_comb begin
        regs = '0;
        for (int i = 0; i < DEPTH; i++)
            regs[i] = (i == ZERO_REG) ? '0 : mem[i < ZERO_REG ? i : i - 1];
    end

    // a new producer's set wins over the old producer's retirement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else if (flush) busy <= '0;
        else busy <= (busy & ~wr_sel) | set_sel;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_read_port #(
            .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_port (
            .reset(reset),
            .regs(regs),
            .busy(busy),
            .addr(rd_addr[p*AW +: AW]),
            .wr_en(wr_en),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .data(rd_data[p*WIDTH +: WIDTH]),
            .pending(rd_busy[p])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against a behavioural model
module tb_regfile_sb;
    logic clk = 0, reset;
    logic [9:0] rd_addr;
    logic [127:0] rd_data, nb_rd_data;
    logic [1:0] rd_busy, nb_rd_busy;
    logic wr_en, busy_set_en, flush;
    logic [4:0] wr_addr, busy_set_addr;
    logic [63:0] wr_data;

    logic [15:0] s_rd_addr;
    logic [127:0] s_rd_data;
    logic [3:0] s_rd_busy;
    logic s_wr_en, s_set_en, s_flush;
    logic [3:0] s_wr_addr, s_set_addr;
    logic [31:0] s_wr_data;

    int checks = 0, errors = 0;
    logic [63:0] m_reg [32];
    bit m_busy [32];
    logic [31:0] s_reg [16];
    bit s_busy [16];

    always #5 clk = ~clk;

    regfile_sb dut (.clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set_en(busy_set_en),
        .busy_set_addr(busy_set_addr), .flush(flush));

    regfile_sb #(.BYPASS(0)) dut_nb (.clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data),
        .rd_busy(nb_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .flush(flush));

    regfile_sb #(.WIDTH(32), .DEPTH(16), .NUM_RD(4), .ZERO_REG(15)) dut_s (.clk(clk), .reset(reset),
        .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy), .wr_en(s_wr_en),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .busy_set_en(s_set_en), .busy_set_addr(s_set_addr),
        .flush(s_flush));

    function automatic logic [63:0] exp_d(input int a, input bit bp);
        if (reset || a == 31) return 64'd0;
        if (bp && wr_en && int'(wr_addr) == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_b(input int a);
        if (reset || a == 31) return 1'b0;
        return m_busy[a] && !(wr_en && int'(wr_addr) == a);
    endfunction

    function automatic logic [31:0] s_exp_d(input int a);
        if (reset || a == 15) return 32'd0;
        if (s_wr_en && int'(s_wr_addr) == a) return s_wr_data;
        return s_reg[a];
    endfunction

    function automatic logic s_exp_b(input int a);
        if (reset || a == 15) return 1'b0;
        return s_busy[a] && !(s_wr_en && int'(s_wr_addr) == a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
        for (int i = 0; i < 16; i++) begin s_reg[i] = 0; s_busy[i] = 0; end
    endtask

    task automatic m_edge();
        if (reset) begin m_clear(); return; end
        if (wr_en && wr_addr != 31) m_reg[wr_addr] = wr_data;
        if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 0;
        else begin
            if (wr_en && wr_addr != 31) m_busy[wr_addr] = 0;
            if (busy_set_en && busy_set_addr != 31) m_busy[busy_set_addr] = 1;
        end
        if (s_wr_en && s_wr_addr != 15) s_reg[s_wr_addr] = s_wr_data;
        if (s_flush) for (int i = 0; i < 16; i++) s_busy[i] = 0;
        else begin
            if (s_wr_en && s_wr_addr != 15) s_busy[s_wr_addr] = 0;
            if (s_set_en && s_set_addr != 15) s_busy[s_set_addr] = 1;
        end
    endtask

    task automatic check_all();
        for (int p = 0; p < 2; p++) begin
            chk("rd_data", rd_data[p*64 +: 64], exp_d(int'(rd_addr[p*5 +: 5]), 1));
            chk("rd_busy", 64'(rd_busy[p]), 64'(exp_b(int'(rd_addr[p*5 +: 5]))));
            chk("nb_rd_data", nb_rd_data[p*64 +: 64], exp_d(int'(rd_addr[p*5 +: 5]), 0));
            chk("nb_rd_busy", 64'(nb_rd_busy[p]), 64'(exp_b(int'(rd_addr[p*5 +: 5]))));
        end
        for (int p = 0; p < 4; p++) begin
            chk("s_rd_data", 64'(s_rd_data[p*32 +: 32]), 64'(s_exp_d(int'(s_rd_addr[p*4 +: 4]))));
            chk("s_rd_busy", 64'(s_rd_busy[p]), 64'(s_exp_b(int'(s_rd_addr[p*4 +: 4]))));
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0; busy_set_en = 0; busy_set_addr = 0; flush = 0;
        s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_set_en = 0; s_set_addr = 0; s_flush = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
    endtask

    task automatic set(input logic [4:0] a);
        busy_set_en = 1; busy_set_addr = a;
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; idle(); rd_addr = 0; s_rd_addr = 0; m_clear();
        repeat (2) @(negedge clk);
        settle();
        chk("rst_data", rd_data[63:0], 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        reset = 0;
        tick();

        // mid-cycle asynchronous reset
        wr(5, 64'hDEAD); settle(); tick();
        idle(); set(6); settle(); tick();
        idle(); rd_addr = {5'd6, 5'd5}; settle();
        chk("x5_before_rst", rd_data[63:0], 64'hDEAD);
        chk("x6_busy_before_rst", 64'(rd_busy[1]), 64'd1);
        #1 reset = 1; m_clear();
        #1 chk("x5_in_rst", rd_data[63:0], 64'd0);
        chk("busy_in_rst", 64'(rd_busy), 64'd0);
        check_all();
        reset = 0;
        tick();
        settle();
        chk("x5_after_rst", rd_data[63:0], 64'd0);
        chk("x6_busy_after_rst", 64'(rd_busy[1]), 64'd0);
        reset = 1; wr(5, 64'hBEEF); set(5); settle(); tick();
        reset = 0; idle(); settle();
        chk("x5_write_in_rst", rd_data[63:0], 64'd0);
        tick();

        // write then read on both ports
        wr(3, 64'h0123_4567_89AB_CDEF); rd_addr = {5'd3, 5'd3}; settle(); tick();
        idle(); settle();
        chk("x3_port0", rd_data[63:0], 64'h0123_4567_89AB_CDEF);
        chk("x3_port1", rd_data[127:64], 64'h0123_4567_89AB_CDEF);
        tick();

        // bypass versus stored value
        wr(7, 64'h11); settle(); tick();
        wr(7, 64'hAA); rd_addr = {5'd3, 5'd7}; settle();
        chk("x7_bypass", rd_data[63:0], 64'hAA);
        chk("x7_nobypass", nb_rd_data[63:0], 64'h11);
        tick();
        idle(); settle();
        chk("x7_nobypass_after", nb_rd_data[63:0], 64'hAA);
        tick();

        // zero register ignores writes and sets
        wr(31, 64'hFFFF); set(31); rd_addr = {5'd31, 5'd31}; settle();
        chk("x31_data_wr", rd_data[63:0], 64'd0);
        chk("x31_busy_wr", 64'(rd_busy[0]), 64'd0);
        tick();
        idle(); settle();
        chk("x31_data", rd_data[127:64], 64'd0);
        chk("x31_busy", 64'(rd_busy[1]), 64'd0);
        tick();
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)}; settle(); tick();
        end

        // set wins over a same-cycle write-clear
        set(9); rd_addr = {5'd9, 5'd9}; settle(); tick();
        idle(); settle();
        chk("x9_busy", 64'(rd_busy[0]), 64'd1);
        wr(9, 64'h99); set(9); #1;
        chk("x9_masked", 64'(rd_busy[0]), 64'd0);
        settle(); tick();
        idle(); settle();
        chk("x9_still_busy", 64'(rd_busy[1]), 64'd1);
        tick();
        wr(9, 64'h9A); settle(); tick();
        idle(); settle();
        chk("x9_cleared", 64'(rd_busy[0]), 64'd0);
        tick();

        // flush drops all busy bits and a same-cycle set
        set(1); settle(); tick();
        set(2); settle(); tick();
        set(4); rd_addr = {5'd2, 5'd1}; settle(); tick();
        idle(); flush = 1; set(6); settle();
        chk("x1_busy_pre_flush", 64'(rd_busy[0]), 64'd1);
        tick();
        idle(); settle();
        chk("x1_flushed", 64'(rd_busy[0]), 64'd0);
        chk("x2_flushed", 64'(rd_busy[1]), 64'd0);
        tick();
        rd_addr = {5'd6, 5'd4}; settle();
        chk("x4_flushed", 64'(rd_busy[0]), 64'd0);
        chk("x6_dropped", 64'(rd_busy[1]), 64'd0);
        tick();

        // random traffic on all builds
        for (int n = 0; n < 600; n++) begin
            wr_en = 1'($urandom); wr_addr = 5'($urandom); wr_data = {$urandom, $urandom};
            busy_set_en = 1'($urandom); busy_set_addr = 5'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            rd_addr = 10'($urandom);
            if ($urandom_range(0, 3) == 0) rd_addr[4:0] = wr_addr;
            s_wr_en = 1'($urandom); s_wr_addr = 4'($urandom); s_wr_data = $urandom;
            s_set_en = 1'($urandom); s_set_addr = 4'($urandom);
            s_flush = ($urandom_range(0, 15) == 0);
            s_rd_addr = 16'($urandom);
            if ($urandom_range(0, 3) == 0) s_rd_addr[7:4] = s_wr_addr;
            settle(); tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
